// File: rtl/delay_sum_serializer_pkg.sv
// Shared constants and state encoding for the beamformer sum/serializer slice.
package delay_sum_serializer_pkg;
    localparam int NUMBER_OF_BITS = 8;
    localparam int NUM_CHANNELS   = 2;
    // Wide enough that the full channel sum can never wrap
    localparam int SUM_W = NUMBER_OF_BITS + $clog2(NUM_CHANNELS);
    localparam int CNT_W = $clog2(NUMBER_OF_BITS);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } state_t;
endpackage

// File: rtl/delay_sum_serializer_channel_summer.sv
// Masked sign-extended channel sum, arithmetic scale-down and saturation to sample width.
module channel_summer
    import delay_sum_serializer_pkg::*;
#(
    parameter int SUM_SHIFT = 1
) (
    input  logic [NUM_CHANNELS*NUMBER_OF_BITS-1:0] ch_data,
    input  logic [NUM_CHANNELS-1:0]                ch_enable,
    output logic [NUMBER_OF_BITS-1:0]              result,
    output logic                                   clipped
);
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((2 ** (NUMBER_OF_BITS - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;

    logic signed [SUM_W-1:0] acc;
    logic signed [SUM_W-1:0] scaled;

    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_enable[i])
                acc = acc + SUM_W'($signed(ch_data[i*NUMBER_OF_BITS +: NUMBER_OF_BITS]));
        end
        scaled  = acc >>> SUM_SHIFT;
        result  = scaled[NUMBER_OF_BITS-1:0];
        clipped = 1'b0;
        if (scaled > MAX_V) begin
            result  = MAX_V[NUMBER_OF_BITS-1:0];
            clipped = 1'b1;
        end else if (scaled < MIN_V) begin
            result  = MIN_V[NUMBER_OF_BITS-1:0];
            clipped = 1'b1;
        end
    end
endmodule

// File: rtl/delay_sum_serializer.sv
// Sums delayed channels at each ws edge and shifts the mono word out MSB-first,
// padding with zeros until the next edge; a new edge always preempts the current word.
module delay_sum_serializer
    import delay_sum_serializer_pkg::*;
#(
    parameter int SUM_SHIFT = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   ws,
    input  logic [NUM_CHANNELS*NUMBER_OF_BITS-1:0] ch_data_in,
    input  logic [NUM_CHANNELS-1:0]                ch_enable,
    output logic                                   sd_out,
    output logic                                   word_loaded,
    output logic                                   sat_flag
);
    state_t                    state;
    logic                      prev_ws;
    logic                      ws_edge;
    logic [NUMBER_OF_BITS-1:0] shreg;
    logic [CNT_W-1:0]          bit_cnt;
    logic [NUMBER_OF_BITS-1:0] sum_word;
    logic                      clipped;

    channel_summer #(.SUM_SHIFT(SUM_SHIFT)) u_summer (
        .ch_data   (ch_data_in),
        .ch_enable (ch_enable),
        .result    (sum_word),
        .clipped   (clipped)
    );

    assign ws_edge = (ws != prev_ws);

    // shreg holds the bits still to be sent; the MSB goes straight to sd_out on load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SYNC;
            prev_ws     <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            sd_out      <= 1'b0;
            word_loaded <= 1'b0;
            sat_flag    <= 1'b0;
        end else begin
            prev_ws     <= ws;
            word_loaded <= 1'b0;
            sat_flag    <= 1'b0;
            if (ws_edge) begin
                state       <= SHIFT;
                sd_out      <= sum_word[NUMBER_OF_BITS-1];
                shreg       <= {sum_word[NUMBER_OF_BITS-2:0], 1'b0};
                bit_cnt     <= '0;
                word_loaded <= 1'b1;
                sat_flag    <= clipped;
            end else begin
                case (state)
                    SHIFT: begin
                        if (bit_cnt == CNT_W'(NUMBER_OF_BITS - 1)) begin
                            state  <= PAD;
                            sd_out <= 1'b0;
                        end else begin
                            sd_out  <= shreg[NUMBER_OF_BITS-1];
                            shreg   <= {shreg[NUMBER_OF_BITS-2:0], 1'b0};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    SYNC, PAD: sd_out <= 1'b0;
                    default: begin
                        state  <= SYNC;
                        sd_out <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_delay_sum_serializer.sv
// Directed bench: instance A uses SUM_SHIFT=1, instance B uses SUM_SHIFT=0, sharing stimulus.
module tb_delay_sum_serializer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ws = 1'b0;
    logic [15:0] ch_data = '0;
    logic [1:0]  ch_en = '0;
    logic        sd_a, wl_a, sf_a, sd_b, wl_b, sf_b;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic [7:0] c0;
        logic [7:0] c1;
        logic [1:0] en;
        logic [7:0] ea;
        logic       sa;
        logic [7:0] eb;
        logic       sb;
    } vec_t;
    vec_t vt[9];

    always #5 clk = ~clk;

    delay_sum_serializer #(.SUM_SHIFT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ws(ws), .ch_data_in(ch_data), .ch_enable(ch_en),
        .sd_out(sd_a), .word_loaded(wl_a), .sat_flag(sf_a)
    );
    delay_sum_serializer #(.SUM_SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ws(ws), .ch_data_in(ch_data), .ch_enable(ch_en),
        .sd_out(sd_b), .word_loaded(wl_b), .sat_flag(sf_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [7:0] c0, input logic [7:0] c1, input logic [1:0] en);
        ch_data = {c1, c0};
        ch_en   = en;
        ws      = ~ws;
        tick();
    endtask

    // Starts with bit 0 already on sd; scrambles the inputs after the load edge
    task automatic grab(output logic [7:0] wa, output logic [7:0] wb);
        wa = '0;
        wb = '0;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) tick();
            wa = {wa[6:0], sd_a};
            wb = {wb[6:0], sd_b};
            if (j == 0) begin
                ch_data = ~ch_data;
                ch_en   = ~ch_en;
            end
        end
    endtask

    initial begin
        logic [7:0] wa, wb;
        logic [3:0] head;
        logic       quiet;

        vt[0] = '{8'h40, 8'h20, 2'b11, 8'h30, 1'b0, 8'h60, 1'b0};
        vt[1] = '{8'h80, 8'h80, 2'b11, 8'h80, 1'b0, 8'h80, 1'b1};
        vt[2] = '{8'hF0, 8'h7F, 2'b01, 8'hF8, 1'b0, 8'hF0, 1'b0};
        vt[3] = '{8'h7F, 8'h01, 2'b11, 8'h40, 1'b0, 8'h7F, 1'b1};
        vt[4] = '{8'h80, 8'hFF, 2'b11, 8'hBF, 1'b0, 8'h80, 1'b1};
        vt[5] = '{8'h12, 8'h34, 2'b00, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[6] = '{8'h7F, 8'h7F, 2'b11, 8'h7F, 1'b0, 8'h7F, 1'b1};
        vt[7] = '{8'hFF, 8'h00, 2'b11, 8'hFF, 1'b0, 8'hFF, 1'b0};
        vt[8] = '{8'h55, 8'h40, 2'b10, 8'h20, 1'b0, 8'h40, 1'b0};

        // Reset held while ws toggles: nothing may come out
        for (int i = 0; i < 3; i++) begin
            ws = ~ws;
            tick();
            chk("reset_quiet", {28'd0, sd_a, sd_b, wl_a, wl_b}, 32'd0);
        end
        ws    = 1'b0;
        rst_n = 1'b1;
        quiet = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            quiet = quiet | sd_a | sd_b | wl_a | wl_b;
        end
        chk("idle_after_reset", {31'd0, quiet}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            load(vt[v].c0, vt[v].c1, vt[v].en);
            chk($sformatf("v%0d_wl_a", v), {31'd0, wl_a}, 32'd1);
            chk($sformatf("v%0d_sat_a", v), {31'd0, sf_a}, {31'd0, vt[v].sa});
            chk($sformatf("v%0d_wl_b", v), {31'd0, wl_b}, 32'd1);
            chk($sformatf("v%0d_sat_b", v), {31'd0, sf_b}, {31'd0, vt[v].sb});
            grab(wa, wb);
            chk($sformatf("v%0d_word_a", v), {24'd0, wa}, {24'd0, vt[v].ea});
            chk($sformatf("v%0d_word_b", v), {24'd0, wb}, {24'd0, vt[v].eb});
            quiet = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                quiet = quiet | sd_a | sd_b | wl_a | wl_b | sf_a | sf_b;
            end
            chk($sformatf("v%0d_pad", v), {31'd0, quiet}, 32'd0);
        end

        // Short slot: only 4 MSBs of 0x7E, then the next word follows at once
        load(8'h7E, 8'h7E, 2'b11);
        head = '0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) tick();
            head = {head[2:0], sd_a};
        end
        chk("short_head", {28'd0, head}, 32'h7);
        load(8'hA0, 8'hC0, 2'b11);
        chk("short_reload_wl", {30'd0, wl_a, wl_b}, 32'h3);
        chk("short_reload_sat", {30'd0, sf_a, sf_b}, 32'h1);
        grab(wa, wb);
        chk("short_next_a", {24'd0, wa}, 32'hB0);
        chk("short_next_b", {24'd0, wb}, 32'h80);
        quiet = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            quiet = quiet | sd_a | sd_b | wl_a | wl_b;
        end
        chk("full_slot_pad24", {31'd0, quiet}, 32'd0);

        // Reset in the middle of a word
        load(8'h7F, 8'h7F, 2'b11);
        for (int j = 1; j < 4; j++) tick();
        chk("mid_word_bit3", {31'd0, sd_a}, 32'd1);
        rst_n = 1'b0;
        ws    = 1'b0;
        tick();
        chk("mid_reset_sd", {29'd0, sd_a, sd_b, wl_a}, 32'd0);
        tick();
        rst_n = 1'b1;
        quiet = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            quiet = quiet | sd_a | sd_b | wl_a | wl_b;
        end
        chk("post_reset_wait", {31'd0, quiet}, 32'd0);
        load(8'h40, 8'h20, 2'b11);
        chk("post_reset_wl", {31'd0, wl_a}, 32'd1);
        grab(wa, wb);
        chk("post_reset_word", {24'd0, wa}, 32'h30);

        // ws high at release: the first cycle is already an edge
        rst_n = 1'b0;
        ws    = 1'b1;
        ch_data = {8'h20, 8'h40};
        ch_en   = 2'b11;
        tick();
        tick();
        chk("rst_hold_wl", {31'd0, wl_a}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("first_cycle_edge_wl", {30'd0, wl_a, wl_b}, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
